// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the fetch PC, indexes program memory and
// buffers fetched words in a 2-entry queue toward decode.
module fetch_controller #(
  parameter int                        DATA_WIDTH   = 32,
  parameter int                        MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0]     TEXT_BASE    = 32'h0040_0000
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  halt_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  input  logic                  ready_i,
  input  logic [DATA_WIDTH-1:0] mem_instruction_i,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  fault_o
);

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} mode_t;

  localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(MEMORY_DEPTH);

  mode_t                 mode_q, mode_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] pc0_q, pc0_d, instr0_q, instr0_d;
  logic [DATA_WIDTH-1:0] pc1_q, pc1_d, instr1_q, instr1_d;

  logic [DATA_WIDTH-1:0] word_idx;
  logic                  legal, pop, fetch, wr_head;

  // Unsigned wrap makes PCs below TEXT_BASE huge; the explicit >= check covers them anyway.
  assign word_idx = (fetch_pc_q - TEXT_BASE) >> 2;
  assign legal    = (fetch_pc_q[1:0] == 2'b00) && (fetch_pc_q >= TEXT_BASE) &&
                    (word_idx < DEPTH_W);
  assign pop      = (count_q != 2'd0) && ready_i;
  assign fetch    = (mode_q == RUN) && !halt_i && !redirect_i && legal &&
                    ((count_q != 2'd2) || pop);
  assign wr_head  = (count_q == 2'd0) || ((count_q == 2'd1) && pop);

  assign mem_addr_o    = word_idx;
  assign instr_valid_o = (count_q != 2'd0);
  assign instr_o       = instr_valid_o ? instr0_q : '0;
  assign pc_o          = instr_valid_o ? pc0_q : '0;
  assign fault_o       = (mode_q == FAULT);

  always_comb begin
    mode_d     = mode_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    pc0_d      = pc0_q;
    instr0_d   = instr0_q;
    pc1_d      = pc1_q;
    instr1_d   = instr1_q;

    if (redirect_i) begin
      // A head popped in this same cycle is treated as consumed by decode.
      fetch_pc_d = redirect_pc_i;
      count_d    = 2'd0;
      mode_d     = RUN;
    end else begin
      if ((mode_q == RUN) && !legal && !halt_i) begin
        mode_d = FAULT;
      end
      if (pop) begin
        pc0_d    = pc1_q;
        instr0_d = instr1_q;
      end
      if (fetch) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        if (wr_head) begin
          pc0_d    = fetch_pc_q;
          instr0_d = mem_instruction_i;
        end else begin
          pc1_d    = fetch_pc_q;
          instr1_d = mem_instruction_i;
        end
      end
      case ({fetch, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      mode_q     <= RUN;
      fetch_pc_q <= TEXT_BASE;
      count_q    <= 2'd0;
      pc0_q      <= '0;
      instr0_q   <= '0;
      pc1_q      <= '0;
      instr1_q   <= '0;
    end else begin
      mode_q     <= mode_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      pc0_q      <= pc0_d;
      instr0_q   <= instr0_d;
      pc1_q      <= pc1_d;
      instr1_q   <= instr1_d;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a combinational ROM where rom[i] = 0x100 + i.
module tb_fetch_controller;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        halt_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        ready_i = 1'b1;
  logic [31:0] mem_instruction_i;
  logic [31:0] mem_addr_o;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        fault_o;

  int checks = 0;
  int errors = 0;

  fetch_controller dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .halt_i           (halt_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .ready_i          (ready_i),
    .mem_instruction_i(mem_instruction_i),
    .mem_addr_o       (mem_addr_o),
    .instr_valid_o    (instr_valid_o),
    .instr_o          (instr_o),
    .pc_o             (pc_o),
    .fault_o          (fault_o)
  );

  always #5 clk_i = ~clk_i;

  assign mem_instruction_i = (mem_addr_o < 32'd64) ? (32'h100 + mem_addr_o) : 32'h0;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input int word);
    chk({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd1);
    chk({tag, "_instr"}, instr_o, 32'h100 + word);
    chk({tag, "_pc"}, pc_o, 32'h0040_0000 + 32'(word * 4));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd0);
    chk({tag, "_instr"}, instr_o, 32'd0);
    chk({tag, "_pc"}, pc_o, 32'd0);
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk_empty("reset");
    chk("reset_fault", {31'd0, fault_o}, 32'd0);
    chk("reset_addr", mem_addr_o, 32'd0);

    // streaming at one per cycle from the first released edge
    reset_n_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_head("stream", k);
      chk("stream_fault", {31'd0, fault_o}, 32'd0);
    end

    // backpressure: queue fills to 2, fetch address freezes
    ready_i = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk_head("stall", 3);
    chk("stall_addr", mem_addr_o, 32'd5);
    ready_i = 1'b1;
    for (int k = 4; k < 8; k++) begin
      tick();
      chk_head("drain", k);
    end

    // redirect with full queue: one bubble, then target word
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0040_0020;
    tick();
    redirect_i = 1'b0;
    chk_empty("redir_flush");
    chk("redir_addr", mem_addr_o, 32'd8);
    tick();
    chk_head("redir_tgt", 8);
    tick();
    chk_head("redir_next", 9);

    // out-of-range target faults one edge after evaluation
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0040_0100;
    tick();
    redirect_i = 1'b0;
    chk("oor_fault0", {31'd0, fault_o}, 32'd0);
    chk("oor_addr", mem_addr_o, 32'd64);
    tick();
    chk("oor_fault1", {31'd0, fault_o}, 32'd1);
    chk("oor_valid", {31'd0, instr_valid_o}, 32'd0);
    tick();
    chk("oor_hold", {31'd0, fault_o}, 32'd1);
    chk("oor_nopush", {31'd0, instr_valid_o}, 32'd0);

    // misaligned target
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0040_0002;
    tick();
    redirect_i = 1'b0;
    chk("mis_clear", {31'd0, fault_o}, 32'd0);
    tick();
    chk("mis_fault", {31'd0, fault_o}, 32'd1);
    chk("mis_valid", {31'd0, instr_valid_o}, 32'd0);

    // recovery
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0040_0004;
    tick();
    redirect_i = 1'b0;
    chk("rec_fault", {31'd0, fault_o}, 32'd0);
    chk_empty("rec_bubble");
    tick();
    chk_head("rec_tgt", 1);
    chk("rec_addr", mem_addr_o, 32'd2);

    // halt: queue drains, address frozen, resume without skip
    halt_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("halt_valid", {31'd0, instr_valid_o}, 32'd0);
      chk("halt_addr", mem_addr_o, 32'd2);
    end
    halt_i = 1'b0;
    tick();
    chk_head("halt_resume", 2);

    // fill queue to top of memory, then fault with queue full
    ready_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0040_00F8;
    tick();
    redirect_i = 1'b0;
    tick();
    tick();
    tick();
    chk("full_fault", {31'd0, fault_o}, 32'd1);
    chk_head("full_head", 62);
    chk("full_addr", mem_addr_o, 32'd64);

    // mid-operation reset
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    chk_empty("rst2");
    chk("rst2_fault", {31'd0, fault_o}, 32'd0);
    chk("rst2_addr", mem_addr_o, 32'd0);
    ready_i = 1'b1;
    tick();
    chk_head("rst2_first", 0);
    chk("rst2_fault_after", {31'd0, fault_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
